seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Time-multiplexed scan scheduler for the 4-digit 7-segment display. Steps an
//   8-slot ping-pong select code (1..8) into the existing digit-select decoder
//   and drives matching active-low segment data per slot. Data is double-buffered
//   and swapped only at frame boundaries, so a frame never mixes old and new values.
//   A ghost-suppression blank precedes each slot.
// PARAMETERS
//   SLOT_CYC   50000  clock cycles per slot (1 ms at 50 MHz); must be >= 2
//   BLANK_CYC  500    leading dark cycles per slot; must satisfy 1 <= BLANK_CYC < SLOT_CYC
// PORTS
//   clk         in   1   system clock, rising edge
//   rst         in   1   asynchronous, active-high reset
//   en          in   1   scan enable (level)
//   load        in   1   1-cycle pulse: capture data_in/dp_in/blank_in into pending buffer
//   data_in     in   16  hex digits; [3:0]=digit0 ... [15:12]=digit3
//   dp_in       in   4   decimal point per digit, 1=lit
//   blank_in    in   4   per-digit blank mask, 1=digit dark
//   sel         out  4   select code to digit-select decoder (0 when idle, else 1..8)
//   seg_data    out  8   active-low segments {dp,g,f,e,d,c,b,a}
//   frame_done  out  1   1-cycle pulse at end of slot 8
//   busy        out  1   1 while scanning (state != IDLE)
// BEHAVIOUR
//   - All outputs registered. Reset values: sel=4'h0, seg_data=8'hFF,
//     frame_done=0, busy=0; active/pending buffers cleared (data 0, dp 0, blank 4'hF).
//   - Slot->digit map: code 1/8->digit0, 2/7->digit1, 3/6->digit2, 4/5->digit3.
//   - FSM states: IDLE, BLANK, SHOW; slot counter cnt (width $clog2(SLOT_CYC)),
//     code register 1..8.
//     IDLE : sel=0, seg=FF. en=1 -> BLANK, code=1, cnt=0 on next edge.
//     BLANK: seg=FF, sel=code; cnt==BLANK_CYC-1 -> SHOW.
//     SHOW : seg=font(active digit) unless blanked; cnt==SLOT_CYC-1 -> BLANK,
//            code=code+1, wrapping 8->1, cnt=0.
//   - en=0 in any state -> IDLE on next edge. Outputs go to idle values on that
//     edge. Counters and code reset. Re-enable always restarts at code 1 in BLANK.
//   - Font (hex, dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90
//     A=88 B=83 C=C6 D=A1 E=86 F=8E. dp lit clears bit7. Blanked digit -> 8'hFF
//     including dp.
//   - load: pending <= inputs, pend_flag=1. A load in the same cycle as a swap
//     captures the new values into pending and sets pend_flag again.
//   - Swap: active <= pending and pend_flag cleared in two cases:
//     (a) on the edge where code wraps 8->1;
//     (b) in IDLE, on the edge after a load.
//   - frame_done asserts for exactly 1 cycle, on the same edge as the 8->1 wrap.
//     No pulse if en drops before slot 8 completes.
//   - Frame period = 8*SLOT_CYC cycles. Each digit is lit 2*(SLOT_CYC-BLANK_CYC)
//     cycles per frame.
//   - rst asserted at any time forces reset values immediately, without waiting
//     for a clock edge.
// TESTING (SLOT_CYC=8, BLANK_CYC=2)
//   1 rst pulse mid-SHOW with no clk edge -> sel=0, seg_data=FF, busy=0 at once.
//   2 load data_in=16'h1234, dp=0, blank=0 in IDLE; en=1 ->
//     sel 1..8 then back to 1, each code held 8 cycles;
//     first 2 cycles of each slot seg=FF;
//     slot1 seg=99, slot4 seg=F9, slot5 seg=F9, slot8 seg=99;
//     frame_done pulses once, on the edge ending cycle 64.
//   3 Mid slot 3, load 16'hABCD -> rest of frame still shows 1234;
//     after wrap, slot1 seg=A1 and slot4 seg=88.
//   4 blank_in=4'b0010, dp_in=4'b0001 -> slots 2 and 7 stay FF for the whole slot;
//     slot1 shows digit0 with bit7=0.
//   5 en=0 during slot 5 SHOW -> next edge sel=0, seg=FF, busy=0, no frame_done;
//     en=1 again -> BLANK at code 1.
//   6 load and 8->1 wrap on the same edge -> the swap occurs, and the new
//     pending values become active at the following wrap.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 4-digit 7-segment display: steps an 8-slot ping-pong
// select code, blanks the start of each slot, and swaps double-buffered data only at frame ends.
module seg_scan_ctrl #(
    parameter int SLOT_CYC  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  sel,
    output logic [7:0]  seg_data,
    output logic        frame_done,
    output logic        busy
);

    localparam int CW = $clog2(SLOT_CYC);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    logic [1:0]    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [3:0]    code, code_next;
    logic          wrap;
    logic          swap;

    logic [15:0]   act_data, pend_data;
    logic [3:0]    act_dp, pend_dp;
    logic [3:0]    act_blank, pend_blank;
    logic          pend_flag;

    logic [1:0]    digit;
    logic [3:0]    nibble;
    logic [7:0]    font_bits;
    logic [7:0]    seg_next;
    logic [3:0]    sel_next;

    function automatic logic [7:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    // Ping-pong order: codes 1..4 walk digits 0..3, codes 5..8 walk back 3..0.
    function automatic logic [1:0] digit_of(input logic [3:0] c);
        case (c)
            4'd1, 4'd8: return 2'd0;
            4'd2, 4'd7: return 2'd1;
            4'd3, 4'd6: return 2'd2;
            default:    return 2'd3;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        code_next  = code;
        wrap       = 1'b0;
        if (!en) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            code_next  = 4'd1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    code_next  = 4'd1;
                end
                ST_BLANK: begin
                    cnt_next = cnt + 1'b1;
                    if (cnt == BLANK_LAST) state_next = ST_SHOW;
                end
                ST_SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        state_next = ST_BLANK;
                        cnt_next   = '0;
                        if (code == 4'd8) begin
                            code_next = 4'd1;
                            wrap      = 1'b1;
                        end else begin
                            code_next = code + 4'd1;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    code_next  = 4'd1;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_comb begin
        digit     = digit_of(code_next);
        nibble    = act_data[{digit, 2'b00} +: 4];
        font_bits = hex_font(nibble);
        seg_next  = 8'hFF;
        if (state_next == ST_SHOW && !act_blank[digit])
            seg_next = {~act_dp[digit], font_bits[6:0]};
        sel_next = (state_next == ST_IDLE) ? 4'd0 : code_next;
    end

    assign swap = wrap || (state == ST_IDLE && pend_flag);

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            code       <= 4'd1;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= 4'hF;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= 4'hF;
            pend_flag  <= 1'b0;
            sel        <= 4'd0;
            seg_data   <= 8'hFF;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            code       <= code_next;
            sel        <= sel_next;
            seg_data   <= seg_next;
            frame_done <= wrap;
            busy       <= (state_next != ST_IDLE);
            if (swap) begin
                act_data  <= pend_data;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
            // A load on a swap edge wins the flag: the fresh values still await the next swap.
            if (load) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
                pend_flag  <= 1'b1;
            end else if (swap) begin
                pend_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised scoreboard bench for seg_scan_ctrl: a frame-time model predicts
// every output cycle, a separate negedge monitor pops and compares.
module tb_seg_scan_ctrl;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  sel;
    logic [7:0]  seg_data;
    logic        frame_done;
    logic        busy;

    seg_scan_ctrl #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
        .sel(sel), .seg_data(seg_data), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
        logic       fd;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: scan position is just elapsed cycles since enable.
    bit          running;
    int          t;
    logic [15:0] m_act_d, m_pend_d;
    logic [3:0]  m_act_p, m_pend_p, m_act_b, m_pend_b;
    bit          m_pflag;
    bit          m_wrap, m_swap;
    int          m_slot, m_off, m_digit;
    logic [3:0]  m_nib;
    exp_t        m_exp;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                running = 0; t = 0; m_pflag = 0;
                m_act_d = '0; m_act_p = '0; m_act_b = 4'hF;
                m_pend_d = '0; m_pend_p = '0; m_pend_b = 4'hF;
                exp_q.delete();
            end else begin
                m_wrap = en && running && ((t + 1) % FRAME == 0);
                m_swap = m_wrap || (!running && m_pflag);
                if (!en) running = 0;
                else if (!running) begin running = 1; t = 0; end
                else t = t + 1;
                if (m_swap) begin
                    m_act_d = m_pend_d; m_act_p = m_pend_p; m_act_b = m_pend_b; m_pflag = 0;
                end
                if (load) begin
                    m_pend_d = data_in; m_pend_p = dp_in; m_pend_b = blank_in; m_pflag = 1;
                end
                m_exp.fd   = m_wrap;
                m_exp.busy = running;
                m_exp.sel  = 4'd0;
                m_exp.seg  = 8'hFF;
                if (running) begin
                    m_slot    = (t / SLOT) % 8;
                    m_off     = t % SLOT;
                    m_digit   = (m_slot < 4) ? m_slot : 7 - m_slot;
                    m_exp.sel = 4'(m_slot + 1);
                    m_nib     = m_act_d[m_digit*4 +: 4];
                    if (m_off >= BLANK && !m_act_b[m_digit])
                        m_exp.seg = {~m_act_p[m_digit], font[m_nib][6:0]};
                end
                exp_q.push_back(m_exp);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sel", 32'(sel), 32'(e.sel));
                check("seg_data", 32'(seg_data), 32'(e.seg));
                check("frame_done", 32'(frame_done), 32'(e.fd));
                check("busy", 32'(busy), 32'(e.busy));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        load = 1'b1; data_in = d; dp_in = dp; blank_in = bl;
        step();
        load = 1'b0;
    endtask

    // Waits until the model sits at the given frame position; a timeout counts as a failure.
    task automatic wait_pos(input int pos);
        bit hit = 0;
        for (int i = 0; i < 3 * FRAME && !hit; i++) begin
            if (running && (t % FRAME) == pos) hit = 1;
            else step();
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_pos: position %0d never reached", pos);
        end
    endtask

    initial begin
        step(3);
        check("reset_sel", 32'(sel), 32'h0);
        check("reset_seg", 32'(seg_data), 32'hFF);
        check("reset_fd", 32'(frame_done), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        step(2);

        // Plain frame of 1234, then a wrap back to code 1.
        do_load(16'h1234, 4'h0, 4'h0);
        step(2);
        en = 1'b1;
        step(FRAME + 10);

        // Load mid slot 3: the current frame must keep the old data.
        wait_pos(2 * SLOT + 4);
        do_load(16'hABCD, 4'h0, 4'h0);
        step(FRAME + 4 * SLOT);

        // Blanked digit 1 and lit dp on digit 0.
        do_load(16'($urandom), 4'b0001, 4'b0010);
        step(2 * FRAME + 4);

        // Drop enable during slot 5 SHOW, then restart.
        wait_pos(4 * SLOT + 3);
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(20);

        // Load on the very edge where code wraps 8->1.
        do_load(16'h5A5A, 4'h0, 4'h0);
        wait_pos(FRAME - 1);
        do_load(16'hC3E7, 4'b1010, 4'b0100);
        step(2 * FRAME + 4);

        // Asynchronous reset between clock edges while a digit is shown.
        wait_pos(2 * SLOT + 5);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sel", 32'(sel), 32'h0);
        check("async_rst_seg", 32'(seg_data), 32'hFF);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_fd", 32'(frame_done), 32'h0);
        step(2);
        rst = 1'b0;

        // Random traffic: occasional enable drops and frequent loads.
        for (int i = 0; i < 600; i++) begin
            en      = ($urandom_range(0, 39) != 0);
            load    = ($urandom_range(0, 7) == 0);
            data_in = 16'($urandom);
            dp_in   = 4'($urandom);
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step();
        end
        load = 1'b0;
        en   = 1'b0;
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
